// File: rtl/sfr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sfr_pkg : shared widths, FSM states and request bundle for the   |
// |           SFR arbiter                                            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package sfr_pkg;

  localparam int SFR_AW = 8;
  localparam int SFR_DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } sfr_arb_state_t;

  typedef struct packed {
    logic [SFR_AW-1:0] addr;
    logic              r;
    logic [1:0]        w;
    logic [SFR_DW-1:0] dwrite;
  } sfr_req_t;

endpackage
`default_nettype wire

// File: rtl/sfr_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sfr_rr_pick : combinational two-way round-robin picker           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sfr_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // On a tie the master that was not granted last wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sfr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sfr_arbiter : two-master round-robin arbiter and three-phase     |
// |               sequencer for the SFR port. Optional master lock   |
// |               enabled by macro SFR_ARB_LOCK_EN.                   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sfr_arbiter
  import sfr_pkg::*;
#(
  parameter int AW = SFR_AW,
  parameter int DW = SFR_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_r,
  input  logic [1:0]    m0_w,
  input  logic [DW-1:0] m0_dwrite,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_r,
  input  logic [1:0]    m1_w,
  input  logic [DW-1:0] m1_dwrite,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
`ifdef SFR_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  output logic          s_sel,
  output logic [AW-1:0] s_addr,
  output logic          s_r,
  output logic [1:0]    s_w,
  output logic [DW-1:0] s_dwrite,
  input  logic [DW-1:0] s_data
);

  sfr_arb_state_t r_state;
  logic           r_last;
  logic           r_win;
  logic           r_s_sel;
  logic [AW-1:0]  r_s_addr;
  logic           r_s_r;
  logic [1:0]     r_s_w;
  logic [DW-1:0]  r_s_dwrite;
  logic           r_m0_ack;
  logic           r_m1_ack;
  logic [DW-1:0]  r_m0_rdata;
  logic [DW-1:0]  r_m1_rdata;

  logic [1:0]     w_req;
  logic [1:0]     w_grant;
  logic           w_win;

`ifdef SFR_ARB_LOCK_EN
  logic           r_locked;
  logic           r_owner;
  logic           w_lock;
  assign w_lock = w_win ? m1_lock : m0_lock;
`endif

  // While locked only the owner's request is visible to the picker.
  always_comb begin
    w_req = {m1_req, m0_req};
`ifdef SFR_ARB_LOCK_EN
    if (r_locked) begin
      w_req = r_owner ? {m1_req, 1'b0} : {1'b0, m0_req};
    end
`endif
  end

  sfr_rr_pick u_pick (
    .req   (w_req),
    .last  (r_last),
    .grant (w_grant)
  );

  assign w_win = w_grant[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_win      <= 1'b0;
      r_s_sel    <= 1'b0;
      r_s_addr   <= '0;
      r_s_r      <= 1'b0;
      r_s_w      <= 2'b00;
      r_s_dwrite <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
`ifdef SFR_ARB_LOCK_EN
      r_locked   <= 1'b0;
      r_owner    <= 1'b0;
`endif
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_state    <= ISSUE;
            r_last     <= w_win;
            r_win      <= w_win;
            r_s_sel    <= 1'b1;
            r_s_addr   <= w_win ? m1_addr   : m0_addr;
            r_s_r      <= w_win ? m1_r      : m0_r;
            r_s_w      <= w_win ? m1_w      : m0_w;
            r_s_dwrite <= w_win ? m1_dwrite : m0_dwrite;
`ifdef SFR_ARB_LOCK_EN
            r_locked   <= w_lock;
            r_owner    <= w_win;
`endif
          end
        end
        ISSUE: begin
          // sfr has committed any write on the falling edge; capture and release the port.
          r_state    <= ACK;
          if (r_win) begin
            r_m1_rdata <= s_data;
          end else begin
            r_m0_rdata <= s_data;
          end
          r_m0_ack   <= ~r_win;
          r_m1_ack   <= r_win;
          r_s_sel    <= 1'b0;
          r_s_addr   <= '0;
          r_s_r      <= 1'b0;
          r_s_w      <= 2'b00;
          r_s_dwrite <= '0;
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_sel    = r_s_sel;
  assign s_addr   = r_s_addr;
  assign s_r      = r_s_r;
  assign s_w      = r_s_w;
  assign s_dwrite = r_s_dwrite;
  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;

endmodule
`default_nettype wire
